// File: rtl/usb_ft1248_pkg.sv
// Shared types for the FT1248 bus-master engine: sequencer states and command opcodes.
package usb_ft1248_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StCommand,
    StStatus,
    StData,
    StDeselect
  } e_ft_state;

  typedef enum logic [7:0] {
    CMD_WRITE              = 8'h00,
    CMD_WRITE_BUFFER_FLUSH = 8'h08,
    CMD_READ_MODEM_STATUS  = 8'h20,
    CMD_READ               = 8'h40,
    CMD_WRITE_MODEM_STATUS = 8'h60
  } e_ft_cmd;

  function automatic int unsigned beats_per_byte(int unsigned width);
    return 8 / width;
  endfunction

endpackage

// File: rtl/usb_ft1248_clkgen.sv
// FT1248 bus-clock divider: one bus period is 2*HALF_PERIOD clk cycles, high half first.
module usb_ft1248_clkgen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic ft_clk_o,
  output logic sample_o,
  output logic half_end_o
);
  localparam int unsigned Period = 2 * HALF_PERIOD;
  localparam int unsigned CntW   = $clog2(Period);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != CntW'(Period - 1))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ft_clk_o   = run_i && (cnt_q < CntW'(HALF_PERIOD));
  assign sample_o   = run_i && (cnt_q == CntW'(Period - 1));
  assign half_end_o = run_i && (cnt_q == CntW'(HALF_PERIOD - 1));

endmodule

// File: rtl/usb_ft1248_engine.sv
// FT1248 bus-master transaction engine: runs one host command per request over a
// 1/2/4/8-lane bus; a NAK'd write byte is kept and sent first on the next write.
module usb_ft1248_engine
  import usb_ft1248_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned LEN_W       = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_cmd,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 done_valid,
  output logic [LEN_W-1:0]     done_count,
  output logic                 done_nak,
  input  logic                 tx_valid,
  input  logic [7:0]           tx_data,
  output logic                 tx_pop,
  input  logic                 rx_space,
  output logic                 rx_write,
  output logic [7:0]           rx_data,
  output logic [7:0]           status_data,
  output logic                 ft_clk,
  output logic                 ft_cs,
  input  logic                 ft_miso,
  input  logic [BUS_WIDTH-1:0] ft_miosi_in,
  output logic [BUS_WIDTH-1:0] ft_miosi_out,
  output logic                 ft_oe
);
  localparam int unsigned Beats = beats_per_byte(BUS_WIDTH);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  e_ft_state        state_q, state_d;
  logic [7:0]       cmd_q, cmd_d, cmd_sh_q, cmd_sh_d;
  logic [7:0]       sh_q, sh_d, byte_q, byte_d, rx_sh_q, rx_sh_d, status_q, status_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d, count_inc;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             nak_q, nak_d, retain_q, retain_d, init_q;
  logic             sample, half_end, clk_lvl, last_beat, open_byte;
  logic             is_write, is_read, is_wms;
  logic [8+BUS_WIDTH-1:0] rx_cat;

  usb_ft1248_clkgen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clkgen (
    .clk_i     (clk),
    .reset_i   (reset),
    .run_i     (state_q != StIdle),
    .ft_clk_o  (clk_lvl),
    .sample_o  (sample),
    .half_end_o(half_end)
  );

  assign is_write  = (cmd_q == CMD_WRITE);
  assign is_read   = (cmd_q == CMD_READ);
  assign is_wms    = (cmd_q == CMD_WRITE_MODEM_STATUS);
  assign last_beat = (beat_q == BeatW'(Beats - 1));
  assign rx_cat    = {rx_sh_q, ft_miosi_in};
  assign rx_data   = rx_cat[7:0];
  assign count_inc = (&count_q) ? count_q : count_q + LEN_W'(1);
  assign req_ready = (state_q == StIdle) && init_q;
  // Kept apart from the next-state logic so a sink may derive rx_space from it.
  assign rx_write  = (state_q == StData) && sample && last_beat && !ft_miso && is_read;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_sh_d   = cmd_sh_q;
    len_d      = len_q;
    count_d    = count_q;
    nak_d      = nak_q;
    sh_d       = sh_q;
    byte_d     = byte_q;
    rx_sh_d    = rx_sh_q;
    status_d   = status_q;
    retain_d   = retain_q;
    beat_d     = beat_q;
    open_byte  = 1'b0;
    tx_pop     = 1'b0;
    done_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          cmd_d    = req_cmd;
          cmd_sh_d = req_cmd;
          len_d    = req_len;
          count_d  = '0;
          nak_d    = 1'b0;
          beat_d   = '0;
          state_d  = StSelect;
        end
      end
      StSelect: if (sample) state_d = StCommand;
      StCommand: begin
        if (sample) begin
          cmd_sh_d = cmd_sh_q << BUS_WIDTH;
          beat_d   = last_beat ? '0 : beat_q + BeatW'(1);
          if (last_beat) state_d = StStatus;
        end
      end
      StStatus: begin
        if (sample) begin
          if (ft_miso) begin
            nak_d   = 1'b1;
            state_d = StDeselect;
          end else begin
            open_byte = 1'b1;
          end
        end
      end
      StData: begin
        if (sample) begin
          rx_sh_d = rx_cat[7:0];
          sh_d    = sh_q << BUS_WIDTH;
          beat_d  = last_beat ? '0 : beat_q + BeatW'(1);
          if (last_beat && ft_miso) begin
            nak_d    = 1'b1;
            retain_d = retain_q | is_write;
            state_d  = StDeselect;
          end else if (last_beat) begin
            count_d = count_inc;
            if (is_write || is_read) begin
              retain_d  = 1'b0;
              open_byte = 1'b1;
            end else begin
              if (!is_wms) status_d = rx_cat[7:0];
              state_d = StDeselect;
            end
          end
        end
      end
      StDeselect: begin
        if (half_end) begin
          done_valid = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Byte boundary: decide whether another data byte follows and what it carries.
    if (open_byte) begin
      state_d = StData;
      beat_d  = '0;
      if ((len_q != '0) && (count_d >= len_q)) begin
        state_d = StDeselect;
      end else if (is_write) begin
        if (retain_d) begin
          sh_d = byte_q;
        end else if (tx_valid) begin
          byte_d = tx_data;
          sh_d   = tx_data;
          tx_pop = 1'b1;
        end else begin
          state_d = StDeselect;
        end
      end else if (is_read) begin
        if (!rx_space) state_d = StDeselect;
      end else if (is_wms) begin
        sh_d = tx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      cmd_sh_q <= '0;
      len_q    <= '0;
      count_q  <= '0;
      nak_q    <= 1'b0;
      sh_q     <= '0;
      byte_q   <= '0;
      rx_sh_q  <= '0;
      status_q <= '0;
      retain_q <= 1'b0;
      beat_q   <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmd_sh_q <= cmd_sh_d;
      len_q    <= len_d;
      count_q  <= count_d;
      nak_q    <= nak_d;
      sh_q     <= sh_d;
      byte_q   <= byte_d;
      rx_sh_q  <= rx_sh_d;
      status_q <= status_d;
      retain_q <= retain_d;
      beat_q   <= beat_d;
      init_q   <= 1'b1;
    end
  end

  always_comb begin
    ft_cs        = !((state_q == StSelect) || (state_q == StCommand) ||
                     (state_q == StStatus) || (state_q == StData));
    ft_clk       = clk_lvl && (state_q != StDeselect);
    ft_oe        = 1'b0;
    ft_miosi_out = '1;
    if (state_q == StCommand) begin
      ft_oe        = 1'b1;
      ft_miosi_out = cmd_sh_q[7 -: BUS_WIDTH];
    end else if ((state_q == StData) && (is_write || is_wms)) begin
      ft_oe        = 1'b1;
      ft_miosi_out = sh_q[7 -: BUS_WIDTH];
    end
  end

  assign done_count  = count_q;
  assign done_nak    = nak_q;
  assign status_data = status_q;

endmodule

// File: tb/tb_usb_ft1248_engine.sv
// Directed bench for usb_ft1248_engine: an 8-lane and a 4-lane instance driven by a
// cycle-level FT1248 device model that scripts status/ACK/NAK and read data.
module tb_usb_ft1248_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic req_valid8 = 1'b0, req_valid4 = 1'b0;
  logic [7:0] req_cmd = 8'h00;
  logic [10:0] req_len = 11'd0;
  logic tx_valid, rx_space, ft_miso = 1'b0;
  logic [7:0] tx_data, dev_lanes = 8'h00;

  logic req_ready8, done_valid8, done_nak8, tx_pop8, rx_write8, ft_clk8, ft_cs8, ft_oe8;
  logic [10:0] done_count8;
  logic [7:0] rx_data8, status8, out8;
  logic req_ready4, done_valid4, done_nak4, tx_pop4, rx_write4, ft_clk4, ft_cs4, ft_oe4;
  logic [10:0] done_count4;
  logic [7:0] rx_data4, status4;
  logic [3:0] out4;

  usb_ft1248_engine #(.BUS_WIDTH(8), .HALF_PERIOD(2), .LEN_W(11)) dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid8), .req_ready(req_ready8),
    .req_cmd(req_cmd), .req_len(req_len), .done_valid(done_valid8),
    .done_count(done_count8), .done_nak(done_nak8), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_pop(tx_pop8), .rx_space(rx_space), .rx_write(rx_write8),
    .rx_data(rx_data8), .status_data(status8), .ft_clk(ft_clk8), .ft_cs(ft_cs8),
    .ft_miso(ft_miso), .ft_miosi_in(dev_lanes), .ft_miosi_out(out8), .ft_oe(ft_oe8)
  );

  usb_ft1248_engine #(.BUS_WIDTH(4), .HALF_PERIOD(2), .LEN_W(11)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_cmd(req_cmd), .req_len(req_len), .done_valid(done_valid4),
    .done_count(done_count4), .done_nak(done_nak4), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_pop(tx_pop4), .rx_space(rx_space), .rx_write(rx_write4),
    .rx_data(rx_data4), .status_data(status4), .ft_clk(ft_clk4), .ft_cs(ft_cs4),
    .ft_miso(ft_miso), .ft_miosi_in(dev_lanes[3:0]), .ft_miosi_out(out4), .ft_oe(ft_oe4)
  );

  int errors = 0, checks = 0;

  // Host-side tx source and rx sink
  logic [7:0] tx_arr [0:7];
  int tx_base = 0, tx_n = 0, pop_total = 0, pop4_total = 0, tx_idx;
  int rx_n = 0, rx_base = 0, rx_cap = 100;
  int rx_log [0:63];
  logic [7:0] rx4_last = 8'h00;
  assign tx_idx   = pop_total - tx_base;
  assign tx_valid = tx_idx < tx_n;
  assign tx_data  = tx_arr[tx_idx % 8];
  // Sink counts a byte being strobed this cycle as already taking a slot.
  assign rx_space = ((rx_n - rx_base) + (rx_write8 ? 1 : 0)) < rx_cap;

  always @(posedge clk) begin
    if (tx_pop8) pop_total <= pop_total + 1;
    if (tx_pop4) pop4_total <= pop4_total + 1;
    if (rx_write8) begin
      rx_log[rx_n % 64] <= int'(rx_data8);
      rx_n <= rx_n + 1;
    end
    if (rx_write4) rx4_last <= rx_data4;
  end

  // Device model: counts ft_clk rises since chip select and scripts each period.
  logic sel4 = 1'b0, dev_status_nak = 1'b0, prev_clk = 1'b0, status_oe = 1'b0;
  logic [7:0] dev_rd [0:15];
  int dev_nak_byte = -1, m_k = 0, cyc = 0, last_rise = 0, per = 0;
  int mw, mb, mask, dd, bi, be, wr_sh = 0, wr_n = 0;
  int cmd_log [0:7];
  int wr_log [0:63];
  logic m_cs, m_clk, m_oe;
  logic [7:0] m_out;
  assign m_cs  = sel4 ? ft_cs4 : ft_cs8;
  assign m_clk = sel4 ? ft_clk4 : ft_clk8;
  assign m_oe  = sel4 ? ft_oe4 : ft_oe8;
  assign m_out = sel4 ? {4'h0, out4} : out8;

  always @(negedge clk) begin
    mw   = sel4 ? 4 : 8;
    mb   = 8 / mw;
    mask = (1 << mw) - 1;
    cyc  = cyc + 1;
    if (m_cs) begin
      m_k = 0; prev_clk = 1'b0; ft_miso = 1'b0;
    end else begin
      if (m_clk && !prev_clk) begin
        m_k = m_k + 1;
        per = cyc - last_rise;
        last_rise = cyc;
        ft_miso = 1'b0;
        if (m_k >= 2 && m_k <= mb + 1) begin
          cmd_log[m_k - 2] = int'(m_out) & mask;
        end else if (m_k == mb + 2) begin
          ft_miso = dev_status_nak;
          status_oe = m_oe;
        end else if (m_k > mb + 2) begin
          dd = m_k - mb - 3; bi = dd / mb; be = dd % mb;
          dev_lanes = 8'((int'(dev_rd[bi % 16]) >> (8 - mw * (be + 1))) & mask);
          if (be == mb - 1 && bi == dev_nak_byte) ft_miso = 1'b1;
          if (m_oe) begin
            wr_sh = ((wr_sh << mw) | (int'(m_out) & mask)) & 255;
            if (be == mb - 1) begin
              wr_log[wr_n % 64] = wr_sh;
              wr_n = wr_n + 1;
            end
          end
        end
      end
      prev_clk = m_clk;
    end
  end

  task automatic start_req(input logic [7:0] cmd, input int len, input logic use4);
    int n = 0;
    while (!(use4 ? req_ready4 : req_ready8) && n < 50) begin
      @(negedge clk); n++;
    end
    req_cmd = cmd; req_len = 11'(len);
    if (use4) req_valid4 = 1'b1; else req_valid8 = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0; req_valid8 = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int len, input logic use4);
    int n = 0;
    start_req(cmd, len, use4);
    while (!(use4 ? done_valid4 : done_valid8) && n < 3000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++; $display("FAIL done_timeout: cmd %02h got no done_valid, required one", cmd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready8, ft_cs8, ft_clk8, ft_oe8} !== 4'b0100) begin
      errors++; $display("FAIL reset_ctl: got rdy/cs/clk/oe=%b required 0100",
                         {req_ready8, ft_cs8, ft_clk8, ft_oe8});
    end
    checks++;
    if ({done_valid8, tx_pop8, rx_write8} !== 3'b000 || out8 !== 8'hff || status8 !== 8'h00) begin
      errors++; $display("FAIL reset_out: got dv/pop/rxw=%b out=%02h st=%02h required 000 ff 00",
                         {done_valid8, tx_pop8, rx_write8}, out8, status8);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", req_ready8);
    end
  endtask

  task automatic test_write_ack();
    int pb = pop_total, wb = wr_n;
    tx_arr[0] = 8'h11; tx_arr[1] = 8'h22; tx_arr[2] = 8'h33;
    tx_base = pop_total; tx_n = 3; dev_nak_byte = -1; dev_status_nak = 1'b0;
    run_txn(8'h00, 0, 1'b0);
    checks++;
    if (done_count8 !== 11'd3 || done_nak8 !== 1'b0) begin
      errors++; $display("FAIL wr_done: got count=%0d nak=%b required 3 0", done_count8, done_nak8);
    end
    checks++;
    if (pop_total - pb != 3) begin
      errors++; $display("FAIL wr_pops: got %0d required 3", pop_total - pb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_log[(wb + i) % 64] != 'h11 * (i + 1)) begin
        errors++; $display("FAIL wr_byte%0d: got %02h required %02h", i, wr_log[(wb + i) % 64],
                           'h11 * (i + 1));
      end
    end
    checks++;
    if (cmd_log[0] != 0 || per != 4) begin
      errors++; $display("FAIL wr_bus: got cmd=%02h period=%0d required 00 4", cmd_log[0], per);
    end
  endtask

  task automatic test_write_nak();
    int pb = pop_total, wb;
    tx_arr[0] = 8'h11; tx_arr[1] = 8'h22;
    tx_base = pop_total; tx_n = 2; dev_nak_byte = 1;
    run_txn(8'h00, 0, 1'b0);
    checks++;
    if (done_count8 !== 11'd1 || done_nak8 !== 1'b1 || pop_total - pb != 2) begin
      errors++; $display("FAIL nak_done: got count=%0d nak=%b pops=%0d required 1 1 2",
                         done_count8, done_nak8, pop_total - pb);
    end
    pb = pop_total; wb = wr_n;
    tx_arr[0] = 8'h33; tx_base = pop_total; tx_n = 1; dev_nak_byte = -1;
    run_txn(8'h00, 0, 1'b0);
    checks++;
    if (wr_log[wb % 64] != 'h22 || wr_log[(wb + 1) % 64] != 'h33) begin
      errors++; $display("FAIL resend_bytes: got %02h %02h required 22 33",
                         wr_log[wb % 64], wr_log[(wb + 1) % 64]);
    end
    checks++;
    if (pop_total - pb != 1 || done_count8 !== 11'd2 || done_nak8 !== 1'b0) begin
      errors++; $display("FAIL resend_done: got pops=%0d count=%0d nak=%b required 1 2 0",
                         pop_total - pb, done_count8, done_nak8);
    end
  endtask

  task automatic test_read_space();
    int rb = rx_n;
    dev_rd[0] = 8'haa; dev_rd[1] = 8'hbb; dev_rd[2] = 8'hcc; dev_rd[3] = 8'hdd;
    rx_base = rx_n; rx_cap = 2;
    run_txn(8'h40, 0, 1'b0);
    checks++;
    if (rx_n - rb != 2 || rx_log[rb % 64] != 'haa || rx_log[(rb + 1) % 64] != 'hbb) begin
      errors++; $display("FAIL rd_space: got n=%0d %02h %02h required 2 aa bb",
                         rx_n - rb, rx_log[rb % 64], rx_log[(rb + 1) % 64]);
    end
    checks++;
    if (done_count8 !== 11'd2 || done_nak8 !== 1'b0) begin
      errors++; $display("FAIL rd_space_done: got %0d %b required 2 0", done_count8, done_nak8);
    end
  endtask

  task automatic test_read_len();
    int rb = rx_n;
    for (int i = 0; i < 16; i++) dev_rd[i] = 8'(8'h30 + i);
    rx_base = rx_n; rx_cap = 100;
    run_txn(8'h40, 5, 1'b0);
    checks++;
    if (rx_n - rb != 5 || rx_log[(rb + 4) % 64] != 'h34 || done_count8 !== 11'd5) begin
      errors++; $display("FAIL rd_len: got n=%0d last=%02h count=%0d required 5 34 5",
                         rx_n - rb, rx_log[(rb + 4) % 64], done_count8);
    end
  endtask

  task automatic test_status_nak();
    int pb = pop_total;
    tx_base = pop_total; tx_n = 0; dev_status_nak = 1'b1;
    run_txn(8'h00, 0, 1'b0);
    dev_status_nak = 1'b0;
    checks++;
    if (done_count8 !== 11'd0 || done_nak8 !== 1'b1 || pop_total != pb) begin
      errors++; $display("FAIL status_nak: got count=%0d nak=%b pops=%0d required 0 1 0",
                         done_count8, done_nak8, pop_total - pb);
    end
  endtask

  task automatic test_modem_status();
    int rb = rx_n;
    dev_rd[0] = 8'h5c;
    run_txn(8'h20, 0, 1'b0);
    checks++;
    if (status8 !== 8'h5c || done_count8 !== 11'd1 || rx_n != rb) begin
      errors++; $display("FAIL modem_status: got st=%02h count=%0d rxw=%0d required 5c 1 0",
                         status8, done_count8, rx_n - rb);
    end
  endtask

  task automatic test_width4();
    sel4 = 1'b1; dev_rd[0] = 8'ha5; rx_cap = 100;
    run_txn(8'h40, 1, 1'b1);
    checks++;
    if (cmd_log[0] != 4 || cmd_log[1] != 0 || status_oe !== 1'b0) begin
      errors++; $display("FAIL w4_cmd: got lanes %0h %0h oe=%b required 4 0 0",
                         cmd_log[0], cmd_log[1], status_oe);
    end
    checks++;
    if (rx4_last !== 8'ha5 || done_count4 !== 11'd1 || done_nak4 !== 1'b0) begin
      errors++; $display("FAIL w4_read: got %02h count=%0d nak=%b required a5 1 0",
                         rx4_last, done_count4, done_nak4);
    end
    checks++;
    if (pop4_total != 0 || status4 !== 8'h00) begin
      errors++; $display("FAIL w4_side: got pops=%0d st=%02h required 0 00", pop4_total, status4);
    end
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tx_arr[0] = 8'h11; tx_arr[1] = 8'h22; tx_arr[2] = 8'h33;
    tx_base = pop_total; tx_n = 3;
    start_req(8'h00, 0, 1'b0);
    while (m_k < 4 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL mid_reach_data: got k=%0d required >=4", m_k);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ft_cs8, ft_oe8, req_ready8, done_valid8} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset: got cs/oe/rdy/dv=%b required 1000",
                         {ft_cs8, ft_oe8, req_ready8, done_valid8});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready8 !== 1'b1 || done_valid8 !== 1'b0) begin
      errors++; $display("FAIL mid_ready: got rdy=%b dv=%b required 1 0", req_ready8, done_valid8);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_write_nak();
    test_read_space();
    test_read_len();
    test_status_nak();
    test_modem_status();
    test_width4();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
